plasma_mem_arbiter: RTL and testbench

//  Two-master arbiter for the Plasma external memory port (address/byte_we/data_write/data_read/mem_pause_in).

---
 rtl/plasma_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_plasma_mem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/plasma_mem_arbiter.sv
// Two-master round-robin arbiter for the Plasma external memory port.
// One access in flight at a time; the losing master is held with pause and
// completion is signalled with a one-cycle ack.
module plasma_mem_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byte_we,
   input  logic [DATA_W-1:0]     m0_data_write,
   output logic [DATA_W-1:0]     m0_data_read,
   output logic                  m0_ack,
   output logic                  m0_pause,
   input  logic                  m1_req,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byte_we,
   input  logic [DATA_W-1:0]     m1_data_write,
   output logic [DATA_W-1:0]     m1_data_read,
   output logic                  m1_ack,
   output logic                  m1_pause,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byte_we,
   output logic [DATA_W-1:0]     mem_data_write,
   output logic                  mem_valid,
   input  logic [DATA_W-1:0]     mem_data_read,
   input  logic                  mem_pause_in
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

   state_t              state_q, state_d;
   logic                grant_q, grant_d;
   logic                last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0]   mem_address_d;
   logic [BE_W-1:0]     mem_byte_we_d;
   logic [DATA_W-1:0]   mem_data_write_d;
   logic                mem_valid_d;
   logic [DATA_W-1:0]   m0_data_read_d, m1_data_read_d;
   logic                m0_ack_d, m1_ack_d;

   // Pause tracks the master's own request so a CPU stalls until its ack
   assign m0_pause = m0_req & ~m0_ack;
   assign m1_pause = m1_req & ~m1_ack;

   // Next-state and next-output decode
   always_comb begin
      state_d          = state_q;
      grant_d          = grant_q;
      last_grant_d     = last_grant_q;
      rd_cnt_d         = rd_cnt_q;
      mem_address_d    = mem_address;
      mem_byte_we_d    = '0;
      mem_data_write_d = mem_data_write;
      mem_valid_d      = 1'b0;
      m0_data_read_d   = m0_data_read;
      m1_data_read_d   = m1_data_read;
      m0_ack_d         = 1'b0;
      m1_ack_d         = 1'b0;

      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               // On a tie the master that did not win last time goes first
               grant_d          = (m0_req && m1_req) ? ~last_grant_q : m1_req;
               mem_address_d    = grant_d ? m1_address    : m0_address;
               mem_byte_we_d    = grant_d ? m1_byte_we    : m0_byte_we;
               mem_data_write_d = grant_d ? m1_data_write : m0_data_write;
               mem_valid_d      = 1'b1;
               state_d          = ISSUE;
            end
         end
         ISSUE: begin
            mem_valid_d   = 1'b1;
            mem_byte_we_d = mem_byte_we;
            if (!mem_pause_in) begin
               mem_valid_d   = 1'b0;
               mem_byte_we_d = '0;
               if (mem_byte_we != '0) begin
                  state_d  = DONE;
                  m0_ack_d = ~grant_q;
                  m1_ack_d = grant_q;
               end else begin
                  state_d  = WAIT_RD;
                  rd_cnt_d = CNT_W'(RD_LATENCY - 1);
               end
            end
         end
         WAIT_RD: begin
            if (rd_cnt_q == '0) begin
               if (grant_q) m1_data_read_d = mem_data_read;
               else         m0_data_read_d = mem_data_read;
               m0_ack_d = ~grant_q;
               m1_ack_d = grant_q;
               state_d  = DONE;
            end else begin
               rd_cnt_d = rd_cnt_q - 1'b1;
            end
         end
         DONE: begin
            last_grant_d = grant_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         grant_q        <= 1'b0;
         last_grant_q   <= 1'b1;
         rd_cnt_q       <= '0;
         mem_address    <= '0;
         mem_byte_we    <= '0;
         mem_data_write <= '0;
         mem_valid      <= 1'b0;
         m0_data_read   <= '0;
         m1_data_read   <= '0;
         m0_ack         <= 1'b0;
         m1_ack         <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_grant_q   <= last_grant_d;
         rd_cnt_q       <= rd_cnt_d;
         mem_address    <= mem_address_d;
         mem_byte_we    <= mem_byte_we_d;
         mem_data_write <= mem_data_write_d;
         mem_valid      <= mem_valid_d;
         m0_data_read   <= m0_data_read_d;
         m1_data_read   <= m1_data_read_d;
         m0_ack         <= m0_ack_d;
         m1_ack         <= m1_ack_d;
      end
   end

endmodule

// File: tb/tb_plasma_mem_arbiter.sv
// Directed bench for plasma_mem_arbiter: main instance at RD_LATENCY=2,
// second instance at RD_LATENCY=1 for the short-latency read.
module tb_plasma_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   int          n_checks = 0;
   int          n_errors = 0;

   // Main instance signals
   logic        m0_req, m1_req, m0_ack, m1_ack, m0_pause, m1_pause;
   logic [31:0] m0_address, m1_address, m0_data_write, m1_data_write;
   logic [31:0] m0_data_read, m1_data_read;
   logic [3:0]  m0_byte_we, m1_byte_we, mem_byte_we;
   logic [31:0] mem_address, mem_data_write, mem_data_read;
   logic        mem_valid, mem_pause_in;

   // Short-latency instance signals
   logic        d1_m0_req, d1_m1_req, d1_m0_ack, d1_m1_ack, d1_m0_pause, d1_m1_pause;
   logic [31:0] d1_m0_address, d1_m1_address, d1_m0_data_write, d1_m1_data_write;
   logic [31:0] d1_m0_data_read, d1_m1_data_read;
   logic [3:0]  d1_m0_byte_we, d1_m1_byte_we, d1_mem_byte_we;
   logic [31:0] d1_mem_address, d1_mem_data_write, d1_mem_data_read;
   logic        d1_mem_valid, d1_mem_pause_in;

   always #10 clk = ~clk;

   plasma_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_address(m0_address), .m0_byte_we(m0_byte_we),
      .m0_data_write(m0_data_write), .m0_data_read(m0_data_read),
      .m0_ack(m0_ack), .m0_pause(m0_pause),
      .m1_req(m1_req), .m1_address(m1_address), .m1_byte_we(m1_byte_we),
      .m1_data_write(m1_data_write), .m1_data_read(m1_data_read),
      .m1_ack(m1_ack), .m1_pause(m1_pause),
      .mem_address(mem_address), .mem_byte_we(mem_byte_we),
      .mem_data_write(mem_data_write), .mem_valid(mem_valid),
      .mem_data_read(mem_data_read), .mem_pause_in(mem_pause_in)
   );

   plasma_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .m0_req(d1_m0_req), .m0_address(d1_m0_address), .m0_byte_we(d1_m0_byte_we),
      .m0_data_write(d1_m0_data_write), .m0_data_read(d1_m0_data_read),
      .m0_ack(d1_m0_ack), .m0_pause(d1_m0_pause),
      .m1_req(d1_m1_req), .m1_address(d1_m1_address), .m1_byte_we(d1_m1_byte_we),
      .m1_data_write(d1_m1_data_write), .m1_data_read(d1_m1_data_read),
      .m1_ack(d1_m1_ack), .m1_pause(d1_m1_pause),
      .mem_address(d1_mem_address), .mem_byte_we(d1_mem_byte_we),
      .mem_data_write(d1_mem_data_write), .mem_valid(d1_mem_valid),
      .mem_data_read(d1_mem_data_read), .mem_pause_in(d1_mem_pause_in)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks every registered output of the main instance against zero
   task automatic chk_all_zero(input string tag);
      chk({tag, ".mem_valid"},      64'(mem_valid),      64'd0);
      chk({tag, ".mem_address"},    64'(mem_address),    64'd0);
      chk({tag, ".mem_byte_we"},    64'(mem_byte_we),    64'd0);
      chk({tag, ".mem_data_write"}, 64'(mem_data_write), 64'd0);
      chk({tag, ".m0_ack"},         64'(m0_ack),         64'd0);
      chk({tag, ".m1_ack"},         64'(m1_ack),         64'd0);
      chk({tag, ".m0_data_read"},   64'(m0_data_read),   64'd0);
      chk({tag, ".m1_data_read"},   64'(m1_data_read),   64'd0);
   endtask

   initial begin
      reset = 1'b0;
      m0_req = 0; m0_address = '0; m0_byte_we = '0; m0_data_write = '0;
      m1_req = 0; m1_address = '0; m1_byte_we = '0; m1_data_write = '0;
      mem_data_read = 32'h1111_1111; mem_pause_in = 1'b0;
      d1_m0_req = 0; d1_m0_address = '0; d1_m0_byte_we = '0; d1_m0_data_write = '0;
      d1_m1_req = 0; d1_m1_address = '0; d1_m1_byte_we = '0; d1_m1_data_write = '0;
      d1_mem_data_read = 32'h0BAD_BAD0; d1_mem_pause_in = 1'b0;

      // Reset state
      tick(); tick();
      chk_all_zero("reset");
      chk("reset.m0_pause", 64'(m0_pause), 64'd0);
      reset = 1'b1;
      tick();

      // 1: lone m0 read, RD_LATENCY=2, ack in cycle 5
      m0_req = 1; m0_address = 32'h0000_0100; m0_byte_we = 4'h0;
      tick();
      chk("t1.issue_valid", 64'(mem_valid),   64'd1);
      chk("t1.issue_addr",  64'(mem_address), 64'h100);
      chk("t1.issue_we",    64'(mem_byte_we), 64'd0);
      tick();
      chk("t1.wait_valid",  64'(mem_valid),   64'd0);
      tick();
      mem_data_read = 32'hDEAD_BEEF;
      chk("t1.c4_ack",      64'(m0_ack),      64'd0);
      chk("t1.c4_pause",    64'(m0_pause),    64'd1);
      tick();
      chk("t1.c5_ack",      64'(m0_ack),      64'd1);
      chk("t1.c5_data",     64'(m0_data_read), 64'hDEAD_BEEF);
      chk("t1.c5_pause",    64'(m0_pause),    64'd0);
      m0_req = 0; mem_data_read = 32'h2222_2222;
      tick();
      chk("t1.ack_pulse",   64'(m0_ack),      64'd0);
      chk("t1.data_hold",   64'(m0_data_read), 64'hDEAD_BEEF);

      // 2: simultaneous requests after reset, m0 first
      reset = 1'b0; tick(); reset = 1'b1;
      m0_req = 1; m0_address = 32'h200; m0_byte_we = 4'hF; m0_data_write = 32'hA0;
      m1_req = 1; m1_address = 32'h300; m1_byte_we = 4'h1; m1_data_write = 32'hB1;
      tick();
      chk("t2.m0_addr",     64'(mem_address),    64'h200);
      chk("t2.m0_we",       64'(mem_byte_we),    64'hF);
      chk("t2.m0_wdata",    64'(mem_data_write), 64'hA0);
      tick();
      chk("t2.m0_ack",      64'(m0_ack),     64'd1);
      chk("t2.we_cleared",  64'(mem_byte_we), 64'd0);
      chk("t2.m1_pause_a",  64'(m1_pause),   64'd1);
      m0_req = 0;
      tick();
      chk("t2.m1_pause_b",  64'(m1_pause),   64'd1);
      tick();
      chk("t2.m1_addr",     64'(mem_address), 64'h300);
      chk("t2.m1_pause_c",  64'(m1_pause),   64'd1);
      tick();
      chk("t2.m1_ack",      64'(m1_ack),     64'd1);
      chk("t2.m1_pause_d",  64'(m1_pause),   64'd0);

      // 3: both requesting continuously, grants alternate 0,1,0,1
      m0_req = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t3.idle_valid", 64'(mem_valid), 64'd0);
         tick();
         chk("t3.addr", 64'(mem_address), (k % 2 == 0) ? 64'h200 : 64'h300);
         tick();
         chk("t3.m0_ack", 64'(m0_ack), (k % 2 == 0) ? 64'd1 : 64'd0);
         chk("t3.m1_ack", 64'(m1_ack), (k % 2 == 0) ? 64'd0 : 64'd1);
      end
      m0_req = 0; m1_req = 0;
      tick();

      // 4: m1 write stalled by memory for 4 cycles
      m1_req = 1; m1_address = 32'h400; m1_byte_we = 4'b0011; m1_data_write = 32'h1234_5678;
      mem_pause_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4.stall_valid", 64'(mem_valid),      64'd1);
         chk("t4.stall_addr",  64'(mem_address),    64'h400);
         chk("t4.stall_we",    64'(mem_byte_we),    64'h3);
         chk("t4.stall_wdata", 64'(mem_data_write), 64'h1234_5678);
         chk("t4.stall_ack",   64'(m1_ack),         64'd0);
      end
      mem_pause_in = 1'b0;
      tick();
      chk("t4.ack",         64'(m1_ack),      64'd1);
      chk("t4.done_we",     64'(mem_byte_we), 64'd0);
      chk("t4.done_valid",  64'(mem_valid),   64'd0);
      m1_req = 0;
      tick();
      chk("t4.ack_once",    64'(m1_ack),      64'd0);

      // 5: reset asserted during WAIT_RD aborts the read
      m0_req = 1; m0_address = 32'h500; m0_byte_we = 4'h0;
      mem_data_read = 32'h5555_5555;
      tick(); tick();
      chk("t5.wait_valid", 64'(mem_valid), 64'd0);
      reset = 1'b0;
      tick();
      chk_all_zero("t5");
      m0_req = 0; reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5.no_ack", 64'(m0_ack), 64'd0);
         chk("t5.idle",   64'(mem_valid), 64'd0);
      end
      m0_req = 1; m0_address = 32'h600; m0_byte_we = 4'h1;
      m1_req = 1; m1_address = 32'h700; m1_byte_we = 4'h1;
      tick();
      chk("t5.regrant_m0", 64'(mem_address), 64'h600);
      m0_req = 0; m1_req = 0;
      reset = 1'b0; tick(); reset = 1'b1;

      // 6: RD_LATENCY=1 read, ack in cycle 4
      d1_m0_req = 1; d1_m0_address = 32'h0000_0800; d1_m0_byte_we = 4'h0;
      tick();
      chk("t6.issue_addr", 64'(d1_mem_address), 64'h800);
      tick();
      d1_mem_data_read = 32'hCAFE_F00D;
      chk("t6.c3_ack",     64'(d1_m0_ack), 64'd0);
      tick();
      chk("t6.c4_ack",     64'(d1_m0_ack), 64'd1);
      chk("t6.c4_data",    64'(d1_m0_data_read), 64'hCAFE_F00D);
      d1_m0_req = 0; d1_mem_data_read = 32'h9999_9999;
      tick();
      chk("t6.ack_pulse",  64'(d1_m0_ack), 64'd0);
      chk("t6.data_hold",  64'(d1_m0_data_read), 64'hCAFE_F00D);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
